// File: rtl/bus_arbiter_if.sv
// Handshake signals of both bus masters plus the shared system-bus side of bus_arbiter.
// The m0_lock signal exists only when BUS_ARBITER_LOCK_EN is defined.
interface bus_arbiter_if;
  logic        m0_req,   m1_req;
  logic        m0_we,    m1_we;
  logic [15:0] m0_addr,  m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
`ifdef BUS_ARBITER_LOCK_EN
  logic        m0_lock;
`endif
  logic        m0_ack,   m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_oe;
  logic        bus_w,    bus_r;
  logic [15:0] bus_rdata;
  logic        busy;

  // master: the requesters and the bus slaves around the arbiter
  modport master (
`ifdef BUS_ARBITER_LOCK_EN
    output m0_lock,
`endif
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
    output m0_wdata, m1_wdata, bus_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  bus_addr, bus_wdata, bus_oe, bus_w, bus_r, busy
  );

  // slave: the arbiter itself
  modport slave (
`ifdef BUS_ARBITER_LOCK_EN
    input  m0_lock,
`endif
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
    input  m0_wdata, m1_wdata, bus_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata,
    output bus_addr, bus_wdata, bus_oe, bus_w, bus_r, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the 16-bit system bus (IDLE -> ACCESS -> DONE).
// Define BUS_ARBITER_LOCK_EN to add the master 0 lock that keeps multi-word sequences atomic.
module bus_arbiter #(
  parameter int unsigned WAIT_RAM = 1,
  parameter int unsigned WAIT_IO  = 2
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_RAM_C = 4'(WAIT_RAM);
  localparam logic [3:0] WAIT_IO_C  = 4'(WAIT_IO);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;   // 0 = master 0, 1 = master 1
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        lock_hold;
  logic        sel_m1;

`ifdef BUS_ARBITER_LOCK_EN
  assign lock_hold = bus.m0_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // A tie goes to whoever was not granted last, unless master 0 holds the lock.
  assign sel_m1 = !bus.m0_req || (bus.m1_req && !lock_hold && !last_grant_q);

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path through the case infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_d = sel_m1;
          we_d    = sel_m1 ? bus.m1_we    : bus.m0_we;
          addr_d  = sel_m1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
          cnt_d   = addr_d[15] ? WAIT_IO_C : WAIT_RAM_C;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q) m1_rdata_d = bus.bus_rdata;
            else         m0_rdata_d = bus.bus_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q | lock_hold;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // NOTE: the transfer latches carry no reset; IDLE always reloads them before ACCESS or DONE can observe them.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    grant_q <= grant_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    bus.bus_addr  = (state_q == ACCESS) ? addr_q  : 16'h0000;
    bus.bus_wdata = (state_q == ACCESS) ? wdata_q : 16'h0000;
    bus.bus_r     = (state_q == ACCESS) && !we_q;
    bus.bus_w     = (state_q == ACCESS) &&  we_q;
    bus.bus_oe    = (state_q == ACCESS) &&  we_q;
    bus.m0_ack    = (state_q == DONE)   && !grant_q;
    bus.m1_ack    = (state_q == DONE)   &&  grant_q;
    bus.m0_rdata  = m0_rdata_q;
    bus.m1_rdata  = m1_rdata_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule
